ibus_sram_ctrl: RTL

Instruction-side bus controller that sits directly upstream of the fetch stage. It turns the fetch stage's single-word `if_load`/`if_address` request into a timed, read-only access to the shared base SRAM via a request/grant arbiter, and returns `ibus_inst` with the `ibus_stall` handshake the fetch state machine expects. An optional one-entry sequential prefetch buffer hides SRAM latency on straight-line code.

---
 rtl/ibus_sram_ctrl_pkg.sv | 21 ++
 rtl/ibus_pf_buf.sv | 42 ++++
 rtl/ibus_sram_ctrl.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/ibus_sram_ctrl_pkg.sv
// Shared defines for the instruction-bus SRAM controller: data types, the FSM
// state encoding, and the constant values returned for reads and faults.
package ibus_sram_ctrl_pkg;

    typedef logic [31:0] word_t;
    typedef logic        bit_t;

    // addi x0, x0, 0
    localparam word_t      NOP_INST     = 32'h0000_0013;
    localparam logic [3:0] IBUS_BE_READ = 4'h0;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        READ,
        DONE,
        PF_REQ,
        PF_READ
    } ibus_state_t;

endpackage

// File: rtl/ibus_pf_buf.sv
// One-entry sequential prefetch buffer: holds a valid/address/data triple and
// reports a hit when the looked-up address matches the stored one.
module ibus_pf_buf
    import ibus_sram_ctrl_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  flush,
    input  logic  fill,
    input  word_t fill_addr,
    input  word_t fill_data,
    input  word_t lookup_addr,
    output word_t data,
    output logic  hit
);

    logic  valid_reg;
    word_t addr_reg;
    word_t data_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= 1'b0;
            addr_reg  <= '0;
            data_reg  <= '0;
        end else begin
            if (fill) begin
                addr_reg <= fill_addr;
                data_reg <= fill_data;
            end
            // A flush coinciding with a fill leaves the entry invalid.
            if (flush)
                valid_reg <= 1'b0;
            else if (fill)
                valid_reg <= 1'b1;
        end
    end

    assign data = data_reg;
    assign hit  = valid_reg && (addr_reg == lookup_addr);

endmodule

// File: rtl/ibus_sram_ctrl.sv
// Read-only instruction fetch path to the shared base SRAM via a req/gnt arbiter.
// Defining IBUS_PREFETCH_EN adds a one-entry sequential prefetch buffer.
module ibus_sram_ctrl
    import ibus_sram_ctrl_pkg::*;
#(
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          ADDR_WIDTH  = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_load,
    input  logic [31:0]           if_address,
    input  logic                  ibus_flush,
    output logic                  ibus_stall,
    output logic [31:0]           ibus_inst,
    output logic                  ibus_fault,
    output logic                  sram_req,
    input  logic                  sram_gnt,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic                  sram_ce_n,
    output logic                  sram_oe_n,
    output logic                  sram_we_n,
    output logic [3:0]            sram_be_n,
    input  logic [31:0]           sram_data_in
);

    localparam int CW = $clog2(WAIT_CYCLES + 1);

    ibus_state_t           state_reg;
    logic [CW-1:0]         cnt_reg;
    word_t                 inst_reg;
    bit_t                  fault_reg;
    logic                  req_reg;
    logic                  rd_n_reg;
    logic [ADDR_WIDTH-1:0] sram_addr_reg;
    logic                  pf_hit;
    word_t                 pf_rd_data;

    // Aligned and inside [BASE_ADDR, BASE_ADDR + 4*2^ADDR_WIDTH); 33 bits catch underflow.
    function automatic logic addr_ok(input word_t a);
        logic [32:0] off;
        off = {1'b0, a} - {1'b0, BASE_ADDR};
        return (a[1:0] == 2'b00) && ((off >> (ADDR_WIDTH + 2)) == 33'd0);
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] word_idx(input word_t a);
        word_t off;
        off = a - BASE_ADDR;
        return ADDR_WIDTH'(off >> 2);
    endfunction

`ifdef IBUS_PREFETCH_EN
    word_t addr_reg;
    word_t pend_addr_reg;
    logic  pend_reg;
    logic  pf_kill_reg;
    logic  pend_now;
    word_t pend_addr_now;
    logic  pf_fill;

    assign pend_now      = pend_reg || if_load;
    assign pend_addr_now = pend_reg ? pend_addr_reg : if_address;
    assign pf_fill       = (state_reg == PF_READ) && (cnt_reg == '0) && !pf_kill_reg;

    ibus_pf_buf u_pf_buf (
        .clk         (clk),
        .rst         (rst),
        .flush       (ibus_flush),
        .fill        (pf_fill),
        .fill_addr   (addr_reg),
        .fill_data   (sram_data_in),
        .lookup_addr (if_address),
        .data        (pf_rd_data),
        .hit         (pf_hit)
    );
`else
    logic unused_flush;
    assign unused_flush = ibus_flush;
    assign pf_hit       = 1'b0;
    assign pf_rd_data   = NOP_INST;
`endif

    always_comb begin
        ibus_stall = 1'b0;
        unique case (state_reg)
            IDLE:        ibus_stall = if_load && !pf_hit;
            REQ, READ:   ibus_stall = 1'b1;
`ifdef IBUS_PREFETCH_EN
            PF_REQ, PF_READ: ibus_stall = if_load || pend_reg;
`endif
            default:     ibus_stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            inst_reg      <= NOP_INST;
            fault_reg     <= 1'b0;
            req_reg       <= 1'b0;
            rd_n_reg      <= 1'b1;
            sram_addr_reg <= '0;
`ifdef IBUS_PREFETCH_EN
            addr_reg      <= '0;
            pend_addr_reg <= '0;
            pend_reg      <= 1'b0;
            pf_kill_reg   <= 1'b0;
`endif
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (if_load) begin
`ifdef IBUS_PREFETCH_EN
                        addr_reg <= if_address;
`endif
                        state_reg <= DONE;
                        if (pf_hit) begin
                            inst_reg  <= pf_rd_data;
                            fault_reg <= 1'b0;
                        end else if (!addr_ok(if_address)) begin
                            inst_reg  <= NOP_INST;
                            fault_reg <= 1'b1;
                        end else begin
                            sram_addr_reg <= word_idx(if_address);
                            req_reg       <= 1'b1;
                            state_reg     <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (sram_gnt) begin
                        cnt_reg   <= CW'(WAIT_CYCLES - 1);
                        rd_n_reg  <= 1'b0;
                        state_reg <= READ;
                    end
                end
                READ: begin
                    if (cnt_reg == '0) begin
                        inst_reg  <= sram_data_in;
                        fault_reg <= 1'b0;
                        req_reg   <= 1'b0;
                        rd_n_reg  <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                DONE: begin
                    // if_load here is still the request just served.
                    state_reg <= IDLE;
`ifdef IBUS_PREFETCH_EN
                    if (addr_ok(addr_reg + 32'd4)) begin
                        addr_reg      <= addr_reg + 32'd4;
                        sram_addr_reg <= word_idx(addr_reg + 32'd4);
                        req_reg       <= 1'b1;
                        pend_reg      <= 1'b0;
                        pf_kill_reg   <= ibus_flush;
                        state_reg     <= PF_REQ;
                    end
`endif
                end
`ifdef IBUS_PREFETCH_EN
                PF_REQ, PF_READ: begin
                    if (ibus_flush)
                        pf_kill_reg <= 1'b1;
                    if (if_load && !pend_reg) begin
                        pend_reg      <= 1'b1;
                        pend_addr_reg <= if_address;
                    end
                    if (state_reg == PF_REQ) begin
                        if (sram_gnt) begin
                            cnt_reg   <= CW'(WAIT_CYCLES - 1);
                            rd_n_reg  <= 1'b0;
                            state_reg <= PF_READ;
                        end
                    end else if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end else begin
                        req_reg   <= 1'b0;
                        rd_n_reg  <= 1'b1;
                        pend_reg  <= 1'b0;
                        state_reg <= IDLE;
                        // A fetch that arrived during the prefetch is served now.
                        if (pend_now) begin
                            addr_reg  <= pend_addr_now;
                            state_reg <= DONE;
                            if (!pf_kill_reg && !ibus_flush && pend_addr_now == addr_reg) begin
                                inst_reg  <= sram_data_in;
                                fault_reg <= 1'b0;
                            end else if (!addr_ok(pend_addr_now)) begin
                                inst_reg  <= NOP_INST;
                                fault_reg <= 1'b1;
                            end else begin
                                sram_addr_reg <= word_idx(pend_addr_now);
                                req_reg       <= 1'b1;
                                state_reg     <= REQ;
                            end
                        end
                    end
                end
`endif
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign ibus_inst  = inst_reg;
    assign ibus_fault = fault_reg;
    assign sram_req   = req_reg;
    assign sram_addr  = sram_addr_reg;
    assign sram_ce_n  = rd_n_reg;
    assign sram_oe_n  = rd_n_reg;
    assign sram_we_n  = 1'b1;
    assign sram_be_n  = rd_n_reg ? 4'hF : IBUS_BE_READ;

endmodule
